// File: rtl/tcp_pkg.sv
// Shared TCP transmit definitions: FSM encoding, header field bundle, option constants
// and the one's-complement arithmetic used by the checksum path.
package tcp_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_FOLD,
    S_H1,
    S_H2,
    S_H3,
    S_H4,
    S_H5,
    S_OPT,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [7:0] TCP_PROTO    = 8'd6;
  localparam logic [7:0] OPT_KIND_MSS = 8'd2;
  localparam logic [7:0] OPT_KIND_WS  = 8'd3;
  localparam logic [7:0] OPT_NOP      = 8'd1;
  localparam logic [7:0] OPT_LEN_MSS  = 8'd4;
  localparam logic [7:0] OPT_LEN_WS   = 8'd3;
  localparam int         HDR_WORDS    = 5;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dest_ip;
    logic [15:0] src_port;
    logic [15:0] dest_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [15:0] window;
    logic [15:0] urg_ptr;
    logic [5:0]  flags;
    logic        mss_en;
    logic        ws_en;
    logic [15:0] mss;
    logic [7:0]  scale_wnd;
  } tcp_hdr_t;

  // 32-bit add with end-around carry; a second carry cannot occur after the wrap.
  function automatic logic [31:0] one_complement_adder(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[31:0] + {31'd0, s[32]};
  endfunction

  function automatic logic [15:0] fold16(input logic [31:0] s);
    logic [16:0] t;
    t = {1'b0, s[31:16]} + {1'b0, s[15:0]};
    return t[15:0] + {15'd0, t[16]};
  endfunction

endpackage

// File: rtl/tcp_tx_buffer.sv
// Payload store for the TCP transmitter: one write port, one registered read port.
module tcp_tx_buffer #(
  parameter int BUF_WORDS = 256,
  parameter int AW        = 8,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [BUF_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tcp_encoder.sv
// TCP segment transmitter: latches the header, buffers and sums the payload, then
// streams header, options and payload as 32-bit words with the checksum filled in.
module tcp_encoder
  import tcp_pkg::*;
#(
  parameter int BUF_WORDS = 256,
  parameter int AW        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] src_ip,
  input  logic [31:0] dest_ip,
  input  logic [15:0] src_port,
  input  logic [15:0] dest_port,
  input  logic [31:0] seq_num,
  input  logic [31:0] ack_num,
  input  logic [15:0] window,
  input  logic [15:0] urg_ptr,
  input  logic [5:0]  flags,
  input  logic        mss_en,
  input  logic        ws_en,
  input  logic [15:0] mss,
  input  logic [7:0]  scale_wnd,
  input  logic [15:0] len_data,
  input  logic [31:0] pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [31:0] data_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] len_tcp,
  output logic        busy,
  output logic        fin,
  output logic        err
);

  localparam int MAX_BYTES = 4 * BUF_WORDS;

  state_t        state;
  tcp_hdr_t      hdr;
  logic [31:0]   sum;
  logic [31:0]   hdr_sum;
  logic [15:0]   csum;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic [AW:0]   nwords;
  logic [AW:0]   ld_cnt;
  logic [AW:0]   tx_cnt;
  logic          cur_mss;
  logic [3:0]    doff;
  logic [1:0]    opt_cnt;
  logic [16:0]   len_round;
  logic [31:0]   mss_word;
  logic [31:0]   ws_word;
  logic          adv;
  logic          more_data;
  logic          last_opt;
  logic          data_load;
  logic          buf_we;

  assign pl_ready  = (state == S_LOAD);
  assign busy      = (state != S_IDLE);
  assign buf_we    = (state == S_LOAD) && pl_valid;
  assign opt_cnt   = {1'b0, mss_en} + {1'b0, ws_en};
  assign len_round = {1'b0, len_data} + 17'd3;
  assign doff      = 4'(HDR_WORDS) + {3'd0, hdr.mss_en} + {3'd0, hdr.ws_en};
  assign mss_word  = {OPT_KIND_MSS, OPT_LEN_MSS, hdr.mss};
  assign ws_word   = {OPT_NOP, OPT_KIND_WS, OPT_LEN_WS, hdr.scale_wnd};

  assign adv       = out_valid && out_ready;
  assign more_data = (tx_cnt != nwords);
  assign last_opt  = !(cur_mss && hdr.ws_en);
  assign data_load = adv && more_data &&
                     ((state == S_H5 && !hdr.mss_en && !hdr.ws_en) ||
                      (state == S_OPT && last_opt) ||
                      (state == S_DATA));

  // The read address runs one word ahead so rd_data always holds buffer[rp].
  assign rd_addr = data_load ? rp + 1'b1 : rp;

  tcp_tx_buffer #(
    .BUF_WORDS (BUF_WORDS),
    .AW        (AW),
    .DATA_W    (32)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wp),
    .wdata (pl_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Payload sum plus pseudo-header, header (checksum zero) and option words.
  always_comb begin
    hdr_sum = sum;
    hdr_sum = one_complement_adder(hdr_sum, hdr.src_ip);
    hdr_sum = one_complement_adder(hdr_sum, hdr.dest_ip);
    hdr_sum = one_complement_adder(hdr_sum, {8'd0, TCP_PROTO, len_tcp});
    hdr_sum = one_complement_adder(hdr_sum, {hdr.src_port, hdr.dest_port});
    hdr_sum = one_complement_adder(hdr_sum, hdr.seq_num);
    hdr_sum = one_complement_adder(hdr_sum, hdr.ack_num);
    hdr_sum = one_complement_adder(hdr_sum, {doff, 6'd0, hdr.flags, hdr.window});
    hdr_sum = one_complement_adder(hdr_sum, {16'd0, hdr.urg_ptr});
    if (hdr.mss_en) hdr_sum = one_complement_adder(hdr_sum, mss_word);
    if (hdr.ws_en)  hdr_sum = one_complement_adder(hdr_sum, ws_word);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      data_out  <= '0;
      out_valid <= 1'b0;
      fin       <= 1'b0;
      err       <= 1'b0;
      len_tcp   <= '0;
      sum       <= '0;
      wp        <= '0;
      rp        <= '0;
      ld_cnt    <= '0;
      tx_cnt    <= '0;
      nwords    <= '0;
      cur_mss   <= 1'b0;
    end else begin
      fin <= 1'b0;
      err <= 1'b0;
      if (data_load) begin
        rp     <= rp + 1'b1;
        tx_cnt <= tx_cnt + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            if ({1'b0, len_data} > 17'(MAX_BYTES)) begin
              err <= 1'b1;
            end else begin
              hdr <= '{src_ip: src_ip, dest_ip: dest_ip, src_port: src_port,
                       dest_port: dest_port, seq_num: seq_num, ack_num: ack_num,
                       window: window, urg_ptr: urg_ptr, flags: flags, mss_en: mss_en,
                       ws_en: ws_en, mss: mss, scale_wnd: scale_wnd};
              len_tcp <= 16'd20 + {12'd0, opt_cnt, 2'b00} + len_data;
              nwords  <= (AW+1)'(len_round >> 2);
              sum     <= '0;
              wp      <= '0;
              rp      <= '0;
              ld_cnt  <= '0;
              tx_cnt  <= '0;
              state   <= (len_data == 16'd0) ? S_FOLD : S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (pl_valid) begin
            wp     <= wp + 1'b1;
            ld_cnt <= ld_cnt + 1'b1;
            sum    <= one_complement_adder(sum, pl_data);
            if (ld_cnt + 1'b1 == nwords) state <= S_FOLD;
          end
        end
        S_FOLD: begin
          sum       <= hdr_sum;
          csum      <= ~fold16(hdr_sum);
          data_out  <= {hdr.src_port, hdr.dest_port};
          out_valid <= 1'b1;
          state     <= S_H1;
        end
        S_H1: if (adv) begin data_out <= hdr.seq_num; state <= S_H2; end
        S_H2: if (adv) begin data_out <= hdr.ack_num; state <= S_H3; end
        S_H3: if (adv) begin data_out <= {doff, 6'd0, hdr.flags, hdr.window}; state <= S_H4; end
        S_H4: if (adv) begin data_out <= {csum, hdr.urg_ptr}; state <= S_H5; end
        S_H5: begin
          if (adv) begin
            if (hdr.mss_en) begin
              data_out <= mss_word;
              cur_mss  <= 1'b1;
              state    <= S_OPT;
            end else if (hdr.ws_en) begin
              data_out <= ws_word;
              cur_mss  <= 1'b0;
              state    <= S_OPT;
            end else if (more_data) begin
              data_out <= rd_data;
              state    <= S_DATA;
            end else begin
              out_valid <= 1'b0;
              fin       <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_OPT: begin
          if (adv) begin
            if (!last_opt) begin
              data_out <= ws_word;
              cur_mss  <= 1'b0;
            end else if (more_data) begin
              data_out <= rd_data;
              state    <= S_DATA;
            end else begin
              out_valid <= 1'b0;
              fin       <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_DATA: begin
          if (adv) begin
            if (more_data) begin
              data_out <= rd_data;
            end else begin
              out_valid <= 1'b0;
              fin       <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_encoder.sv
// Bench for tcp_encoder: directed and randomized segments checked against a byte-level
// segment model and a receiver-style checksum verification.
module tb_tcp_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_ip = '0, dest_ip = '0, seq_num = '0, ack_num = '0;
  logic [15:0] src_port = '0, dest_port = '0, window = '0, urg_ptr = '0;
  logic [5:0]  flags = '0;
  logic        mss_en = 1'b0, ws_en = 1'b0;
  logic [15:0] mss = '0;
  logic [7:0]  scale_wnd = '0;
  logic [15:0] len_data = '0;
  logic [31:0] pl_data = '0;
  logic        pl_valid = 1'b0;
  logic        pl_ready;
  logic [31:0] data_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] len_tcp;
  logic        busy, fin, err;

  int checks = 0;
  int errors = 0;

  logic [31:0] t_src_ip, t_dest_ip, t_seq, t_ack;
  logic [15:0] t_src_port, t_dest_port, t_window, t_urg, t_mss, t_len_tcp;
  logic [5:0]  t_flags;
  logic        t_mss_en, t_ws_en;
  logic [7:0]  t_scale;
  int          t_len;
  logic [7:0]  t_pl [1024];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  tcp_encoder #(.BUF_WORDS(256), .AW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .src_ip(src_ip), .dest_ip(dest_ip),
    .src_port(src_port), .dest_port(dest_port), .seq_num(seq_num), .ack_num(ack_num),
    .window(window), .urg_ptr(urg_ptr), .flags(flags), .mss_en(mss_en), .ws_en(ws_en),
    .mss(mss), .scale_wnd(scale_wnd), .len_data(len_data), .pl_data(pl_data),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .len_tcp(len_tcp), .busy(busy), .fin(fin), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Receiver view: 16-bit one's-complement sum of pseudo-header plus every segment word.
  function automatic logic [15:0] fold_sum(input logic [31:0] w[$]);
    logic [31:0] s;
    s = 32'(t_src_ip[31:16]) + 32'(t_src_ip[15:0]) + 32'(t_dest_ip[31:16])
      + 32'(t_dest_ip[15:0]) + 32'd6 + 32'(t_len_tcp);
    foreach (w[i]) s = s + 32'(w[i][31:16]) + 32'(w[i][15:0]);
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return s[15:0];
  endfunction

  function automatic logic [31:0] pl_word(input int i);
    return {t_pl[4*i], t_pl[4*i+1], t_pl[4*i+2], t_pl[4*i+3]};
  endfunction

  function automatic void exp_build();
    int nopt;
    nopt = int'(t_mss_en) + int'(t_ws_en);
    t_len_tcp = 16'(20 + 4 * nopt + t_len);
    exp_q.delete();
    exp_q.push_back({t_src_port, t_dest_port});
    exp_q.push_back(t_seq);
    exp_q.push_back(t_ack);
    exp_q.push_back({4'(5 + nopt), 6'd0, t_flags, t_window});
    exp_q.push_back({16'd0, t_urg});
    if (t_mss_en) exp_q.push_back({8'd2, 8'd4, t_mss});
    if (t_ws_en)  exp_q.push_back({8'd1, 8'd3, 8'd3, t_scale});
    for (int i = 0; i < (t_len + 3) / 4; i++) exp_q.push_back(pl_word(i));
    exp_q[4] = {~fold_sum(exp_q), t_urg};
  endfunction

  task automatic set_random(input int len);
    t_src_ip = $urandom; t_dest_ip = $urandom; t_seq = $urandom; t_ack = $urandom;
    t_src_port = 16'($urandom); t_dest_port = 16'($urandom);
    t_window = 16'($urandom); t_urg = 16'($urandom); t_mss = 16'($urandom);
    t_flags = 6'($urandom); t_mss_en = 1'($urandom); t_ws_en = 1'($urandom);
    t_scale = 8'($urandom); t_len = len;
    for (int i = 0; i < 1024; i++) t_pl[i] = (i < len) ? 8'($urandom) : 8'h00;
  endtask

  task automatic drive_fields();
    src_ip = t_src_ip; dest_ip = t_dest_ip; seq_num = t_seq; ack_num = t_ack;
    src_port = t_src_port; dest_port = t_dest_port; window = t_window; urg_ptr = t_urg;
    flags = t_flags; mss_en = t_mss_en; ws_en = t_ws_en; mss = t_mss;
    scale_wnd = t_scale; len_data = 16'(t_len);
  endtask

  task automatic start_seg();
    exp_build();
    drive_fields();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("len_tcp", 32'(len_tcp), 32'(t_len_tcp));
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic load_payload();
    int nw;
    bit rdy_ok;
    nw = (t_len + 3) / 4;
    rdy_ok = 1'b1;
    for (int i = 0; i < nw; i++) begin
      repeat ($urandom_range(0, 2)) begin
        pl_valid = 1'b0; pl_data = $urandom;
        @(posedge clk); #1;
      end
      pl_valid = 1'b1; pl_data = pl_word(i);
      rdy_ok = rdy_ok & pl_ready;
      @(posedge clk); #1;
    end
    pl_valid = 1'b0;
    if (nw > 0) check("pl_ready", 32'(rdy_ok), 32'd1);
  endtask

  // mode 0: always ready, 1: alternate 1/0, 2: random. poke pulses start mid-segment.
  task automatic collect(input int mode, input bit poke);
    logic [31:0] prev_d;
    bit pend, done;
    int last_acc, fin_cyc;
    prev_d = '0; pend = 1'b0; done = 1'b0; last_acc = -1; fin_cyc = -1;
    got_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (fin) begin done = 1'b1; fin_cyc = cyc; break; end
      if (pend) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", data_out, prev_d);
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ((cyc % 2) == 0);
        default: out_ready = 1'($urandom);
      endcase
      if (poke && cyc == 3) begin
        src_ip = $urandom; src_port = 16'($urandom); seq_num = $urandom;
        len_data = 16'($urandom_range(0, 40)); mss_en = ~mss_en; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(data_out); last_acc = cyc; pend = 1'b0;
      end else begin
        pend = out_valid; prev_d = data_out;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b0;
    check("fin_seen", 32'(done), 32'd1);
    if (done) begin
      check("fin_latency", 32'(fin_cyc), 32'(last_acc + 1));
      check("fin_no_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    check("fin_one_cycle", 32'(fin), 32'd0);
    check("idle_after_fin", 32'(busy), 32'd0);
  endtask

  task automatic compare_seg(input string tag);
    check($sformatf("%s.nwords", tag), 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s.w%0d", tag, i), (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx, exp_q[i]);
    check($sformatf("%s.rx_csum_ok", tag), 32'(fold_sum(got_q)), 32'h0000FFFF);
  endtask

  task automatic run_seg(input int mode, input bit poke, input string tag);
    start_seg();
    load_payload();
    collect(mode, poke);
    compare_seg(tag);
  endtask

  task automatic set_case2();
    set_random(10);
    t_src_ip = 32'hC0A80001; t_dest_ip = 32'hC0A80002;
    t_src_port = 16'd5000; t_dest_port = 16'd80;
    t_seq = 32'h0000_2000; t_ack = 32'h0000_1001;
    t_flags = 6'b010000; t_window = 16'h1000; t_urg = 16'd0;
    t_mss_en = 1'b0; t_ws_en = 1'b0;
    for (int i = 0; i < 10; i++) t_pl[i] = 8'(8'h30 + i);
  endtask

  initial begin
    int n;
    bit saw;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.data_out", data_out, 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.fin", 32'(fin), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.pl_ready", 32'(pl_ready), 32'd0);
    check("rst.len_tcp", 32'(len_tcp), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // SYN with MSS option, no payload
    set_random(0);
    t_src_ip = 32'h0A000001; t_dest_ip = 32'h0A000002;
    t_src_port = 16'd1234; t_dest_port = 16'd80; t_seq = 32'h1000; t_ack = 32'd0;
    t_flags = 6'b000010; t_window = 16'hFFFF; t_urg = 16'd0;
    t_mss_en = 1'b1; t_mss = 16'd1460; t_ws_en = 1'b0;
    run_seg(0, 1'b0, "syn");
    check("syn.count", 32'(got_q.size()), 32'd6);
    check("syn.h4", got_q[3], 32'h6002FFFF);
    check("syn.opt", got_q[5], 32'h020405B4);
    check("syn.len_tcp", 32'(len_tcp), 32'd24);

    // ACK carrying "0123456789"
    set_case2();
    run_seg(0, 1'b0, "ack10");
    check("ack10.count", 32'(got_q.size()), 32'd8);
    check("ack10.last", got_q[7], 32'h38390000);
    check("ack10.rx_len", 32'(len_tcp) - 32'd20, 32'd10);

    // Same segment under alternating backpressure
    set_case2();
    run_seg(1, 1'b0, "ack10_bp");

    // Oversized payload
    set_random(1025);
    drive_fields();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("oversize.err", 32'(err), 32'd1);
    check("oversize.busy", 32'(busy), 32'd0);
    check("oversize.valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("oversize.err_pulse", 32'(err), 32'd0);
    check("oversize.still_idle", 32'(busy), 32'd0);

    // Reset while streaming payload
    set_random(40);
    t_mss_en = 1'b0; t_ws_en = 1'b0;
    start_seg();
    load_payload();
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < 7; c++) begin
      if (out_valid) n++;
      @(posedge clk); #1;
    end
    check("abort.words_before", 32'(n), 32'd7);
    reset = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort.data_out", data_out, 32'd0);
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.pl_ready", 32'(pl_ready), 32'd0);
    check("abort.len_tcp", 32'(len_tcp), 32'd0);
    saw = 1'b0;
    repeat (4) begin
      saw = saw | fin | out_valid;
      @(posedge clk); #1;
    end
    check("abort.no_fin", 32'(saw), 32'd0);
    set_random(23);
    run_seg(2, 1'b0, "after_abort");

    // Start pulsed while busy is ignored
    set_random(20);
    run_seg(0, 1'b1, "busy_start");
    check("busy_start.len_tcp", 32'(len_tcp), 32'(t_len_tcp));

    // Randomized segments, including the largest accepted payload
    for (int k = 0; k < 6; k++) begin
      set_random(int'($urandom_range(0, 64)));
      run_seg(2, 1'b0, $sformatf("rand%0d", k));
    end
    set_random(1024);
    run_seg(0, 1'b0, "max_len");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
